abr_prim_flop_sync: RTL and testbench



---
 rtl/abr_prim_flop_sync_pkg.sv | 11 +
 rtl/abr_prim_flop_sync.sv | 45 ++++
 tb/tb_abr_prim_flop_sync.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/abr_prim_flop_sync_pkg.sv
// Shared helpers for the flop-sync primitive: parameter legality checks only.
// No per-instance data lives here; reset constants stay with each instance.
package abr_prim_flop_sync_pkg;

    localparam int unsigned MinWidth = 1;

    function automatic bit width_is_legal(int unsigned width);
        return width >= MinWidth;
    endfunction

endpackage

// File: rtl/abr_prim_flop_sync.sv
// Resettable D-type register bank: captures d_i every rising edge, loads ResetValue
// when rst_b (active-high, synchronous) is sampled high.
module abr_prim_flop_sync
    import abr_prim_flop_sync_pkg::*;
#(
    parameter int unsigned       Width      = 1,
    parameter logic [Width-1:0] ResetValue = '0
) (
    input  logic             clk_i,
    input  logic             rst_b,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    if (!width_is_legal(Width)) begin : gen_width_check
        $error("abr_prim_flop_sync: Width must be at least 1");
    end

    logic [Width-1:0] state_q;

    // rst_b is active-high despite its name; reset wins over d_i.
    always_ff @(posedge clk_i) begin
        if (rst_b) begin
            state_q <= ResetValue;
        end else begin
            state_q <= d_i;
        end
    end

    assign q_o = state_q;

`ifdef ABR_ASSERT_ON
    property p_reset_load;
        @(posedge clk_i) rst_b |=> (q_o == ResetValue);
    endproperty

    property p_capture;
        @(posedge clk_i) !rst_b |=> (q_o == $past(d_i));
    endproperty

    a_reset_load: assert property (p_reset_load);
    a_capture:    assert property (p_capture);
`endif

endmodule

// File: tb/tb_abr_prim_flop_sync.sv
// Self-checking bench for abr_prim_flop_sync: directed steps followed by random
// stimulus against a per-edge reference model of "reset ? constant : data".
module tb_abr_prim_flop_sync;

    localparam logic [3:0]  Rv4   = 4'hA;
    localparam logic [7:0]  RvP   = 8'h05;
    localparam logic [7:0]  RvS   = 8'hFA;
    localparam logic [0:0]  Rv1   = 1'b1;
    localparam logic [31:0] Rv32  = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  d4  = 4'h5;
    logic [7:0]  dp  = 8'h00;
    logic [7:0]  ds  = 8'h00;
    logic [0:0]  d1  = 1'b0;
    logic [31:0] d32 = 32'h0;

    logic [3:0]  q4;
    logic [7:0]  qp;
    logic [7:0]  qs;
    logic [0:0]  q1;
    logic [31:0] q32;

    // Reference model: value each register should hold after the latest edge.
    logic [3:0]  m4;
    logic [7:0]  mp;
    logic [7:0]  ms;
    logic [0:0]  m1;
    logic [31:0] m32;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    abr_prim_flop_sync #(.Width(4), .ResetValue(Rv4)) u_dut4 (
        .clk_i(clk), .rst_b(rst), .d_i(d4), .q_o(q4)
    );
    abr_prim_flop_sync #(.Width(8), .ResetValue(RvP)) u_primary (
        .clk_i(clk), .rst_b(rst), .d_i(dp), .q_o(qp)
    );
    abr_prim_flop_sync #(.Width(8), .ResetValue(RvS)) u_secondary (
        .clk_i(clk), .rst_b(rst), .d_i(ds), .q_o(qs)
    );
    abr_prim_flop_sync #(.Width(1), .ResetValue(Rv1)) u_dut1 (
        .clk_i(clk), .rst_b(rst), .d_i(d1), .q_o(q1)
    );
    abr_prim_flop_sync #(.Width(32), .ResetValue(Rv32)) u_dut32 (
        .clk_i(clk), .rst_b(rst), .d_i(d32), .q_o(q32)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one edge's worth of inputs, clock it, update the model, compare all outputs.
    task automatic step(input logic r, input logic [3:0] a4, input logic [7:0] ap,
                        input logic [7:0] as, input logic [0:0] a1, input logic [31:0] a32);
        rst = r;
        d4  = a4;
        dp  = ap;
        ds  = as;
        d1  = a1;
        d32 = a32;
        @(posedge clk);
        m4  = r ? Rv4  : a4;
        mp  = r ? RvP  : ap;
        ms  = r ? RvS  : as;
        m1  = r ? Rv1  : a1;
        m32 = r ? Rv32 : a32;
        #1;
        chk("model_q4",  {28'h0, q4}, {28'h0, m4});
        chk("model_qp",  {24'h0, qp}, {24'h0, mp});
        chk("model_qs",  {24'h0, qs}, {24'h0, ms});
        chk("model_q1",  {31'h0, q1}, {31'h0, m1});
        chk("model_q32", q32, m32);
        @(negedge clk);
    endtask

    initial begin
        logic [3:0]  snap4;
        logic [31:0] snap32;
        logic [7:0]  sum;

        // Reset load: held for two edges while d_i carries other data.
        step(1'b1, 4'h5, 8'h11, 8'h22, 1'b0, 32'h1234_5678);
        chk("reset_first_edge", {28'h0, q4}, 32'h0000_000A);
        step(1'b1, 4'h5, 8'h33, 8'h44, 1'b0, 32'h0);
        chk("reset_second_edge", {28'h0, q4}, 32'h0000_000A);

        // Paired counters reset to complementary constants.
        chk("pair_primary", {24'h0, qp}, 32'h0000_0005);
        chk("pair_secondary", {24'h0, qs}, 32'h0000_00FA);
        sum = qp + qs;
        chk("pair_sum", {24'h0, sum}, 32'h0000_00FF);

        // Extremes after reset.
        chk("w1_reset", {31'h0, q1}, 32'h1);
        chk("w32_reset", q32, 32'hFFFF_FFFF);

        // Capture with no recovery cycle after release.
        step(1'b0, 4'h1, 8'h00, 8'h00, 1'b0, 32'h8000_0001);
        chk("capture_1", {28'h0, q4}, 32'h1);
        chk("w1_capture_0", {31'h0, q1}, 32'h0);
        chk("w32_capture", q32, 32'h8000_0001);
        step(1'b0, 4'hF, 8'h00, 8'h00, 1'b1, 32'h5A5A_A5A5);
        chk("capture_F", {28'h0, q4}, 32'hF);
        chk("w1_capture_1", {31'h0, q1}, 32'h1);
        chk("w32_capture_mixed", q32, 32'h5A5A_A5A5);
        step(1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 32'h0);
        chk("capture_0", {28'h0, q4}, 32'h0);

        // Reset priority mid-stream.
        step(1'b0, 4'h7, 8'h00, 8'h00, 1'b0, 32'h0);
        chk("pre_reset_7", {28'h0, q4}, 32'h7);
        step(1'b1, 4'h3, 8'h00, 8'h00, 1'b0, 32'h0);
        chk("midstream_reset", {28'h0, q4}, 32'hA);
        step(1'b0, 4'h3, 8'h00, 8'h00, 1'b0, 32'h0);
        chk("post_reset_capture", {28'h0, q4}, 32'h3);

        // Between-edge insensitivity: wiggle inputs away from the rising edge.
        snap4  = q4;
        snap32 = q32;
        #1 rst = 1'b1; d4 = 4'hC; d32 = 32'hDEAD_BEEF;
        #1 rst = 1'b0; d4 = 4'h9;
        #1;
        chk("between_edge_q4", {28'h0, q4}, {28'h0, snap4});
        chk("between_edge_q32", q32, snap32);

        // Random traffic with occasional resets.
        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(7) == 0), 4'($urandom), 8'($urandom), 8'($urandom),
                 1'($urandom), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
